// File: rtl/s64x7_lsu_if.sv
// Wishbone-style data bus between the S64X7 load/store unit (master)
// and the memory system (slave). Widths follow the LSU parameters.
interface s64x7_lsu_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);

  logic [ADDR_W-LSB-1:0] adr_o;
  logic                  cyc_o;
  logic                  stb_o;
  logic [NB-1:0]         sel_o;
  logic                  we_o;
  logic [DATA_W-1:0]     dat_o;
  logic                  ack_i;
  logic [DATA_W-1:0]     dat_i;

  modport master (
    output adr_o, cyc_o, stb_o, sel_o, we_o, dat_o,
    input  ack_i, dat_i
  );

  modport slave (
    input  adr_o, cyc_o, stb_o, sel_o, we_o, dat_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/s64x7_lsu.sv
// S64X7 load/store unit: one outstanding access, byte-lane steering,
// boundary-crossing accesses split into two back-to-back bus beats,
// and a watchdog that aborts unacknowledged bus cycles.
module s64x7_lsu #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 64,
  parameter int SPLIT_EN = 1,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  s64x7_lsu_if.master       bus
);
  localparam int NB   = DATA_W / 8;
  localparam int NB2  = 2 * NB;
  localparam int LSB  = $clog2(NB);
  localparam int IW   = $clog2(DATA_W);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, CYC1, CYC2, DONE} state_t;
  state_t state, state_d;

  logic              we_r, signed_r, split_r;
  logic [1:0]        size_r;
  logic [LSB-1:0]    off_r;
  logic [NB-1:0]     sel2_r;
  logic [DATA_W-1:0] beat1_r;
  logic [WD_W-1:0]   wdog;

  logic [3:0]          n_in;
  logic [LSB-1:0]      off_in;
  logic                illegal_in, cross_in, aligned_in, reject_in;
  logic [NB2-1:0]      lanes_in;
  logic                in_cyc, expire, abort_flag;
  logic [2*DATA_W-1:0] load_cat;
  logic [DATA_W-1:0]   load_result;

  // Zero- or sign-extend the low (8<<sz) bits; full-width loads pass through.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [1:0] sz,
                                               input logic sgn);
    logic [DATA_W-1:0] hi_mask;
    logic              sign;
    int                bits;
    bits = 8 << sz;
    if (bits >= DATA_W) return v;
    hi_mask = {DATA_W{1'b1}} << bits;
    sign    = sgn & v[IW'(bits - 1)];
    return sign ? (v | hi_mask) : (v & ~hi_mask);
  endfunction

  // Naturally aligned stores put the datum on every lane of its size.
  function automatic logic [DATA_W-1:0] repl(input logic [DATA_W-1:0] w,
                                             input logic [1:0] sz);
    case (sz)
      2'd0:    return {NB{w[7:0]}};
      2'd1:    return {(NB/2){w[15:0]}};
      2'd2:    return {(NB/4){w[31:0]}};
      default: return w;
    endcase
  endfunction

  // Misaligned stores rotate byte k onto lane k+off (mod NB), so the same
  // word serves both beats of a split access.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] w,
                                             input logic [LSB-1:0] off);
    logic [2*DATA_W-1:0] t;
    t = {w, w} << {off, 3'b000};
    return t[2*DATA_W-1:DATA_W];
  endfunction

  // Decode the incoming request: size, lane offset, lane masks for both beats.
  always_comb begin
    n_in       = 4'd1 << size_i;
    off_in     = addr_i[LSB-1:0];
    illegal_in = (DATA_W == 32) && (size_i == 2'd3);
    cross_in   = (5'(off_in) + 5'(n_in)) > 5'(NB);
    aligned_in = (4'(off_in) & (n_in - 4'd1)) == 4'd0;
    reject_in  = illegal_in || (cross_in && (SPLIT_EN == 0));
    lanes_in   = ((NB2'(1) << n_in) - NB2'(1)) << off_in;
  end

  // Watchdog expiry and load-data assembly across one or two beats.
  always_comb begin
    in_cyc      = (state == CYC1) || (state == CYC2);
    expire      = (TIMEOUT != 0) && in_cyc && !bus.ack_i && (wdog == WD_LAST);
    abort_flag  = (state == IDLE) ? reject_in : !bus.ack_i;
    load_cat    = {bus.dat_i, (state == CYC1) ? bus.dat_i : beat1_r} >> {off_r, 3'b000};
    load_result = extend(load_cat[DATA_W-1:0], size_r, signed_r);
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (req_i) state_d = reject_in ? DONE : CYC1;
      CYC1: if (bus.ack_i) state_d = split_r ? CYC2 : DONE;
            else if (expire) state_d = DONE;
      CYC2: if (bus.ack_i || expire) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  // Request capture, registered bus outputs, watchdog and completion.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      we_r      <= 1'b0;
      signed_r  <= 1'b0;
      split_r   <= 1'b0;
      size_r    <= '0;
      off_r     <= '0;
      sel2_r    <= '0;
      beat1_r   <= '0;
      wdog      <= '0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      bus.cyc_o <= 1'b0;
      bus.stb_o <= 1'b0;
      bus.we_o  <= 1'b0;
      bus.adr_o <= '0;
      bus.sel_o <= '0;
      bus.dat_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (state == IDLE && req_i) begin
        we_r     <= we_i;
        signed_r <= signed_i;
        size_r   <= size_i;
        off_r    <= off_in;
        split_r  <= cross_in;
        sel2_r   <= lanes_in[NB2-1:NB];
        if (!reject_in) begin
          bus.cyc_o <= 1'b1;
          bus.stb_o <= 1'b1;
          bus.we_o  <= we_i;
          bus.adr_o <= addr_i[ADDR_W-1:LSB];
          bus.sel_o <= lanes_in[NB-1:0];
          bus.dat_o <= aligned_in ? repl(wdata_i, size_i) : rotl(wdata_i, off_in);
        end
      end
      if (in_cyc) begin
        if (bus.ack_i) begin
          beat1_r <= bus.dat_i;
          wdog    <= '0;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
      if (state == CYC1 && bus.ack_i && split_r) begin
        bus.adr_o <= bus.adr_o + 1'b1;
        bus.sel_o <= sel2_r;
      end
      if (state_d == DONE) begin
        bus.cyc_o <= 1'b0;
        bus.stb_o <= 1'b0;
        bus.we_o  <= 1'b0;
        wdog      <= '0;
        done_o    <= 1'b1;
        err_o     <= abort_flag;
        rdata_o   <= (abort_flag || we_r) ? '0 : load_result;
      end
    end
  end
endmodule

// File: tb/tb_s64x7_lsu.sv
// Directed bench for s64x7_lsu: 64-bit split-enabled unit with a short
// watchdog, a 64-bit unit without splitting, and a 32-bit unit.
module tb_s64x7_lsu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic        we = 1'b0, sgn = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [63:0] addr = '0, wdata = '0;

  logic        busy_a, done_a, err_a, busy_b, done_b, err_b, busy_c, done_c, err_c;
  logic [63:0] rdata_a, rdata_b;
  logic [31:0] rdata_c;

  int n_checks = 0;
  int n_errors = 0;

  s64x7_lsu_if #(.DATA_W(64), .ADDR_W(64)) bus_a ();
  s64x7_lsu_if #(.DATA_W(64), .ADDR_W(64)) bus_b ();
  s64x7_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus_c ();

  s64x7_lsu #(.DATA_W(64), .ADDR_W(64), .SPLIT_EN(1), .TIMEOUT(4)) u_a (
    .clk_i(clk), .reset_i(reset), .req_i(req_a), .we_i(we), .size_i(size),
    .signed_i(sgn), .addr_i(addr), .wdata_i(wdata), .busy_o(busy_a),
    .done_o(done_a), .err_o(err_a), .rdata_o(rdata_a), .bus(bus_a.master));

  s64x7_lsu #(.DATA_W(64), .ADDR_W(64), .SPLIT_EN(0), .TIMEOUT(16)) u_b (
    .clk_i(clk), .reset_i(reset), .req_i(req_b), .we_i(we), .size_i(size),
    .signed_i(sgn), .addr_i(addr), .wdata_i(wdata), .busy_o(busy_b),
    .done_o(done_b), .err_o(err_b), .rdata_o(rdata_b), .bus(bus_b.master));

  s64x7_lsu #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1), .TIMEOUT(16)) u_c (
    .clk_i(clk), .reset_i(reset), .req_i(req_c), .we_i(we), .size_i(size),
    .signed_i(sgn), .addr_i(addr[31:0]), .wdata_i(wdata[31:0]), .busy_o(busy_c),
    .done_o(done_c), .err_o(err_c), .rdata_o(rdata_c), .bus(bus_c.master));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus_a.ack_i = 1'b0; bus_a.dat_i = '0;
    bus_b.ack_i = 1'b0; bus_b.dat_i = '0;
    bus_c.ack_i = 1'b0; bus_c.dat_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", {63'd0, bus_a.cyc_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    chk("rst_sel", {56'd0, bus_a.sel_o}, 64'd0);
    chk("rst_adr", {3'd0, bus_a.adr_o}, 64'd0);
    chk("rst_rdata", rdata_a, 64'd0);
    reset = 1'b0;
    step();

    // signed byte load at offset 5
    addr = 64'h5555_5555; size = 2'd0; sgn = 1'b1; we = 1'b0; req_a = 1'b1;
    step(); req_a = 1'b0;
    chk("t1_cyc", {63'd0, bus_a.cyc_o}, 64'd1);
    chk("t1_stb", {63'd0, bus_a.stb_o}, 64'd1);
    chk("t1_sel", {56'd0, bus_a.sel_o}, 64'h20);
    chk("t1_adr", {3'd0, bus_a.adr_o}, 64'h0AAA_AAAA);
    chk("t1_busy", {63'd0, busy_a}, 64'd1);
    chk("t1_done_early", {63'd0, done_a}, 64'd0);
    bus_a.ack_i = 1'b1; bus_a.dat_i = 64'h0000_8100_0000_0000;
    step(); bus_a.ack_i = 1'b0;
    chk("t1_done", {63'd0, done_a}, 64'd1);
    chk("t1_err", {63'd0, err_a}, 64'd0);
    chk("t1_rdata", rdata_a, 64'hFFFF_FFFF_FFFF_FF81);
    chk("t1_cyc_drop", {63'd0, bus_a.cyc_o}, 64'd0);
    step();
    chk("t1_done_pulse", {63'd0, done_a}, 64'd0);
    chk("t1_idle", {63'd0, busy_a}, 64'd0);

    // aligned half store
    addr = 64'h2222_2220; size = 2'd1; sgn = 1'b0; we = 1'b1; wdata = 64'h41; req_a = 1'b1;
    step(); req_a = 1'b0;
    chk("t2_sel", {56'd0, bus_a.sel_o}, 64'h03);
    chk("t2_dat", bus_a.dat_o, 64'h0041_0041_0041_0041);
    chk("t2_we", {63'd0, bus_a.we_o}, 64'd1);
    chk("t2_adr", {3'd0, bus_a.adr_o}, 64'h0444_4444);
    bus_a.ack_i = 1'b1;
    step(); bus_a.ack_i = 1'b0;
    chk("t2_done", {63'd0, done_a}, 64'd1);
    chk("t2_err", {63'd0, err_a}, 64'd0);
    chk("t2_we_drop", {63'd0, bus_a.we_o}, 64'd0);
    step();

    // split unsigned word load
    addr = 64'h1006; size = 2'd2; sgn = 1'b0; we = 1'b0; req_a = 1'b1;
    step(); req_a = 1'b0;
    chk("t3_b1_adr", {3'd0, bus_a.adr_o}, 64'h200);
    chk("t3_b1_sel", {56'd0, bus_a.sel_o}, 64'hC0);
    bus_a.ack_i = 1'b1; bus_a.dat_i = 64'hBBAA_0000_0000_0000;
    step();
    chk("t3_b2_cyc", {63'd0, bus_a.cyc_o}, 64'd1);
    chk("t3_b2_adr", {3'd0, bus_a.adr_o}, 64'h201);
    chk("t3_b2_sel", {56'd0, bus_a.sel_o}, 64'h03);
    chk("t3_b2_done", {63'd0, done_a}, 64'd0);
    bus_a.dat_i = 64'h0000_0000_0000_DDCC;
    step(); bus_a.ack_i = 1'b0;
    chk("t3_done", {63'd0, done_a}, 64'd1);
    chk("t3_rdata", rdata_a, 64'h0000_0000_DDCC_BBAA);
    step();

    // split dword store
    addr = 64'h2003; size = 2'd3; we = 1'b1; wdata = 64'h8877_6655_4433_2211; req_a = 1'b1;
    step(); req_a = 1'b0;
    chk("t4_b1_sel", {56'd0, bus_a.sel_o}, 64'hF8);
    chk("t4_b1_dat", bus_a.dat_o, 64'h5544_3322_1188_7766);
    bus_a.ack_i = 1'b1;
    step();
    chk("t4_b2_sel", {56'd0, bus_a.sel_o}, 64'h07);
    chk("t4_b2_dat", bus_a.dat_o, 64'h5544_3322_1188_7766);
    chk("t4_b2_adr", {3'd0, bus_a.adr_o}, 64'h401);
    step(); bus_a.ack_i = 1'b0;
    chk("t4_done", {63'd0, done_a}, 64'd1);
    chk("t4_err", {63'd0, err_a}, 64'd0);
    step();

    // crossing access without split support
    addr = 64'h1006; size = 2'd2; we = 1'b0; req_b = 1'b1;
    step(); req_b = 1'b0;
    chk("t5_nocyc", {63'd0, bus_b.cyc_o}, 64'd0);
    chk("t5_done", {63'd0, done_b}, 64'd1);
    chk("t5_err", {63'd0, err_b}, 64'd1);
    step();
    chk("t5_idle", {63'd0, busy_b}, 64'd0);

    // illegal dword on the 32-bit unit
    addr = 64'h100; size = 2'd3; req_c = 1'b1;
    step(); req_c = 1'b0;
    chk("t5c_nocyc", {63'd0, bus_c.cyc_o}, 64'd0);
    chk("t5c_done", {63'd0, done_c}, 64'd1);
    chk("t5c_err", {63'd0, err_c}, 64'd1);
    step();

    // signed half load on the 32-bit unit
    addr = 64'h102; size = 2'd1; sgn = 1'b1; req_c = 1'b1;
    step(); req_c = 1'b0;
    chk("c_sel", {60'd0, bus_c.sel_o}, 64'hC);
    chk("c_adr", {34'd0, bus_c.adr_o}, 64'h40);
    bus_c.ack_i = 1'b1; bus_c.dat_i = 32'h80FF_0000;
    step(); bus_c.ack_i = 1'b0;
    chk("c_rdata", {32'd0, rdata_c}, 64'hFFFF_80FF);
    step();

    // watchdog abort with ack never arriving
    addr = 64'h8; size = 2'd3; sgn = 1'b0; req_a = 1'b1;
    step(); req_a = 1'b0;
    chk("t6_cyc0", {63'd0, bus_a.cyc_o}, 64'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t6_cyc_hold", {63'd0, bus_a.cyc_o}, 64'd1);
    end
    step();
    chk("t6_cyc_drop", {63'd0, bus_a.cyc_o}, 64'd0);
    chk("t6_done", {63'd0, done_a}, 64'd1);
    chk("t6_err", {63'd0, err_a}, 64'd1);
    chk("t6_rdata", rdata_a, 64'd0);
    step();

    // reset during the second beat of a split load
    addr = 64'h1006; size = 2'd2; req_a = 1'b1;
    step(); req_a = 1'b0;
    bus_a.ack_i = 1'b1; bus_a.dat_i = 64'h1;
    step(); bus_a.ack_i = 1'b0;
    chk("t7_in_cyc2", {3'd0, bus_a.adr_o}, 64'h201);
    #2 reset = 1'b1;
    #1;
    chk("t7_rst_cyc", {63'd0, bus_a.cyc_o}, 64'd0);
    chk("t7_rst_busy", {63'd0, busy_a}, 64'd0);
    chk("t7_rst_sel", {56'd0, bus_a.sel_o}, 64'd0);
    @(negedge clk); reset = 1'b0;
    step();

    // recovery: unsigned byte load at offset 7
    addr = 64'h7; size = 2'd0; req_a = 1'b1;
    step(); req_a = 1'b0;
    chk("t8_sel", {56'd0, bus_a.sel_o}, 64'h80);
    bus_a.ack_i = 1'b1; bus_a.dat_i = 64'hAB00_0000_0000_0000;
    step(); bus_a.ack_i = 1'b0;
    chk("t8_rdata", rdata_a, 64'hAB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
